// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/D memory arbiter: FSM states, port ids and memory-type encodings.
package mem_arbiter_pkg;

  localparam logic [2:0] MT_X  = 3'd0;
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} arb_state_t;
  typedef enum logic {PORT_IF, PORT_D} arb_port_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_mt;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic [31:0] mem_address;
  logic [31:0] mem_data_input;
  logic [31:0] mem_data_output;
  logic        mem_ld;
  logic        mem_wr;
  logic [2:0]  mem_mt;
  logic        mem_busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_mt, mem_data_output, mem_busy,
    output if_rdata, if_ack, d_rdata, d_ack, err, mem_address, mem_data_input, mem_ld, mem_wr, mem_mt
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_mt, mem_data_output, mem_busy,
    input  if_rdata, if_ack, d_rdata, d_ack, err, mem_address, mem_data_input, mem_ld, mem_wr, mem_mt
  );
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational grant selection. MEM_ARB_RR_EN selects round-robin tie-break;
// otherwise D always beats IF and rr_ptr is ignored.
module mem_arbiter_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic      if_req,
  input  logic      d_req,
  input  arb_port_t rr_ptr,
  output arb_port_t port,
  output logic      vld
);

  always_comb begin
    vld  = if_req | d_req;
    port = PORT_IF;
`ifdef MEM_ARB_RR_EN
    // rr_ptr holds the last served port; a tie goes to the other one
    if (if_req && d_req) port = (rr_ptr == PORT_D) ? PORT_IF : PORT_D;
    else if (d_req)      port = PORT_D;
`else
    if (d_req) port = PORT_D;
`endif
  end

`ifndef MEM_ARB_RR_EN
  logic unused_rr;
  assign unused_rr = rr_ptr;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (IF/D) front end for the shared memory: grant, hold command, pulse mem_ld,
// follow busy, return data with a one-cycle ack. MEM_ARB_RR_EN enables round-robin ties.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CW       = 5
) (
  input logic       clk,
  input logic       reset_n,
  mem_arbiter_if.slave bus
);

  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  arb_state_t      state;
  arb_port_t       gnt, pick_port, rr_ptr;
  logic            pick_vld, tmo, fin;
  logic [CW-1:0]   cnt;

  mem_arbiter_arb_pick u_pick (
    .if_req (bus.if_req),
    .d_req  (bus.d_req),
    .rr_ptr (rr_ptr),
    .port   (pick_port),
    .vld    (pick_vld)
  );

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!reset_n)                    rr_ptr <= PORT_IF;
    else if (state == IDLE && pick_vld) rr_ptr <= pick_port;
  end
`else
  assign rr_ptr = PORT_IF;
`endif

  assign tmo = (cnt == LAST);
  // completion: timeout while waiting for busy, or busy falling / timeout while it is up
  assign fin = ((state == WAIT_BUSY) && !bus.mem_busy && tmo) ||
               ((state == WAIT_DONE) && (!bus.mem_busy || tmo));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= IDLE;
      cnt                <= '0;
      gnt                <= PORT_IF;
      bus.if_ack         <= 1'b0;
      bus.d_ack          <= 1'b0;
      bus.err            <= 1'b0;
      bus.mem_ld         <= 1'b0;
      bus.mem_wr         <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_data_input <= '0;
      bus.mem_mt         <= MT_W;
      bus.if_rdata       <= '0;
      bus.d_rdata        <= '0;
    end else begin
      bus.mem_ld <= 1'b0;
      bus.if_ack <= 1'b0;
      bus.d_ack  <= 1'b0;
      bus.err    <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_vld) begin
            state      <= ISSUE;
            gnt        <= pick_port;
            bus.mem_ld <= 1'b1;
            if (pick_port == PORT_D) begin
              bus.mem_address    <= bus.d_addr;
              bus.mem_wr         <= bus.d_we;
              bus.mem_mt         <= bus.d_mt;
              bus.mem_data_input <= bus.d_wdata;
            end else begin
              bus.mem_address    <= bus.if_addr;
              bus.mem_wr         <= 1'b0;
              bus.mem_mt         <= MT_W;
              bus.mem_data_input <= '0;
            end
          end
        end
        ISSUE: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (bus.mem_busy) begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end else if (tmo) state <= RESP;
          else              cnt   <= cnt + 1'b1;
        end
        WAIT_DONE: begin
          if (!bus.mem_busy) begin
            state <= RESP;
            // store acks leave d_rdata at its previous value
            if (gnt == PORT_IF)   bus.if_rdata <= bus.mem_data_output;
            else if (!bus.mem_wr) bus.d_rdata  <= bus.mem_data_output;
          end else if (tmo) state <= RESP;
          else              cnt   <= cnt + 1'b1;
        end
        RESP: begin
          bus.mem_wr <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (fin) begin
        bus.if_ack <= (gnt == PORT_IF);
        bus.d_ack  <= (gnt == PORT_D);
        bus.err    <= (state == WAIT_BUSY) || bus.mem_busy;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a negedge memory model; tie order follows MEM_ARB_RR_EN.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    arb_port_t   port;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  mt;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mem_dead = 1'b0;
  int   n_chk = 0, n_pass = 0;
  exp_t sb[$];
  logic [31:0] mem [64];

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_WAIT(16), .CW(5)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ld_fmt(input logic [31:0] w, input logic [1:0] a, input logic [2:0] mt);
    logic [7:0]  b = w[8*a +: 8];
    logic [15:0] h = a[1] ? w[31:16] : w[15:0];
    case (mt)
      MT_B:    return {{24{b[7]}}, b};
      MT_BU:   return {24'h0, b};
      MT_H:    return {{16{h[15]}}, h};
      MT_HU:   return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // memory model: sees mem_ld on a negedge, raises busy, completes three negedges later
  initial begin
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0, m_wd = '0, w;
    logic        m_wr = 1'b0;
    logic [2:0]  m_mt = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | i;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'hC0FFEE00;
    bus.mem_busy = 1'b0;
    bus.mem_data_output = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_busy = 1'b0;
        bus.mem_busy = 1'b0;
      end else if (!mem_dead) begin
        if (m_busy) begin
          if (m_cnt == 0) begin
            chk("hold_addr", bus.mem_address, m_addr);
            chk("hold_wr", {31'b0, bus.mem_wr}, {31'b0, m_wr});
            chk("hold_mt", {29'b0, bus.mem_mt}, {29'b0, m_mt});
            chk("hold_wd", bus.mem_data_input, m_wd);
            w = mem[bus.mem_address[7:2]];
            if (bus.mem_wr) begin
              case (bus.mem_mt)
                MT_B, MT_BU: w[8*bus.mem_address[1:0] +: 8] = bus.mem_data_input[7:0];
                MT_H, MT_HU: w[16*bus.mem_address[1] +: 16] = bus.mem_data_input[15:0];
                default:     w = bus.mem_data_input;
              endcase
              mem[bus.mem_address[7:2]] = w;
            end else begin
              bus.mem_data_output = ld_fmt(w, bus.mem_address[1:0], bus.mem_mt);
            end
            m_busy = 1'b0;
            bus.mem_busy = 1'b0;
          end else m_cnt--;
        end else if (bus.mem_ld) begin
          m_busy = 1'b1;
          bus.mem_busy = 1'b1;
          m_cnt = 2;
          m_addr = bus.mem_address;
          m_wr = bus.mem_wr;
          m_mt = bus.mem_mt;
          m_wd = bus.mem_data_input;
        end
      end
    end
  end

  // monitor: pulse shapes, idle gap, ack exclusivity and scoreboard pops
  initial begin
    int          cyc = 0, ld_cyc = 0;
    logic        prev_ld = 1'b0, prev_ack = 1'b0, c_wr = 1'b0;
    logic [31:0] c_addr = '0, c_wd = '0;
    logic [2:0]  c_mt = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        prev_ld = 1'b0;
        prev_ack = 1'b0;
        continue;
      end
      if (prev_ld) chk("ld_pulse", {31'b0, bus.mem_ld}, 32'd0);
      if (bus.mem_ld) begin
        chk("idle_gap", {31'b0, prev_ack}, 32'd0);
        ld_cyc = cyc;
        c_addr = bus.mem_address; c_wr = bus.mem_wr; c_mt = bus.mem_mt; c_wd = bus.mem_data_input;
      end
      if (bus.if_ack || bus.d_ack) begin
        chk("ack_excl", {31'b0, bus.if_ack & bus.d_ack}, 32'd0);
        chk("ack_width", {31'b0, prev_ack}, 32'd0);
        if (sb.size() == 0) chk("sb_empty", 32'(sb.size()), 32'd1);
        else begin
          e = sb.pop_front();
          chk("port", {30'b0, bus.if_ack, bus.d_ack}, (e.port == PORT_D) ? 32'd1 : 32'd2);
          chk("cmd_addr", c_addr, e.addr);
          chk("cmd_wr", {31'b0, c_wr}, {31'b0, e.wr});
          chk("cmd_mt", {29'b0, c_mt}, {29'b0, e.mt});
          chk("cmd_wd", c_wd, e.wd);
          chk("rdata", (e.port == PORT_D) ? bus.d_rdata : bus.if_rdata, e.rdata);
          chk("err", {31'b0, bus.err}, {31'b0, e.err});
          if (e.lat != 0) chk("latency", 32'(cyc - ld_cyc), 32'(e.lat));
        end
      end
      prev_ld = bus.mem_ld;
      prev_ack = bus.if_ack | bus.d_ack;
    end
  end

  task automatic push(input arb_port_t p, input logic [31:0] a, input logic wr, input logic [2:0] mt,
                      input logic [31:0] wd, input logic [31:0] rd, input logic er, input int lat);
    exp_t e;
    e.port = p; e.addr = a; e.wr = wr; e.mt = mt; e.wd = wd; e.rdata = rd; e.err = er; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic set_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] mt);
    bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_mt = mt;
  endtask

  // raise requests and drop each one at the negedge its ack is seen
  task automatic serve(input logic want_if, input logic want_d);
    logic pend_if = want_if, pend_d = want_d;
    int   n = 0;
    bus.if_req = want_if;
    bus.d_req  = want_d;
    while ((pend_if || pend_d) && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.if_ack) begin bus.if_req = 1'b0; pend_if = 1'b0; end
      if (bus.d_ack)  begin bus.d_req  = 1'b0; pend_d  = 1'b0; end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    chk("req_done", {30'b0, pend_if, pend_d}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_if_ack"}, {31'b0, bus.if_ack}, 32'd0);
    chk({tag, "_d_ack"}, {31'b0, bus.d_ack}, 32'd0);
    chk({tag, "_err"}, {31'b0, bus.err}, 32'd0);
    chk({tag, "_ld"}, {31'b0, bus.mem_ld}, 32'd0);
    chk({tag, "_wr"}, {31'b0, bus.mem_wr}, 32'd0);
    chk({tag, "_addr"}, bus.mem_address, 32'd0);
    chk({tag, "_wd"}, bus.mem_data_input, 32'd0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
    chk({tag, "_mt"}, {29'b0, bus.mem_mt}, {29'b0, MT_W});
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_mt = MT_W;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // IF only
    bus.if_addr = 32'h10;
    push(PORT_IF, 32'h10, 1'b0, MT_W, 32'h0, 32'hDEADBEEF, 1'b0, 4);
    serve(1'b1, 1'b0);

    // D byte load with sign extension
    set_d(1'b0, 32'h23, 32'h0, MT_B);
    push(PORT_D, 32'h23, 1'b0, MT_B, 32'h0, 32'hFFFFFFC0, 1'b0, 0);
    serve(1'b0, 1'b1);

    // D word store; d_rdata keeps the byte-load result
    set_d(1'b1, 32'h20, 32'h12345678, MT_W);
    push(PORT_D, 32'h20, 1'b1, MT_W, 32'h12345678, 32'hFFFFFFC0, 1'b0, 0);
    serve(1'b0, 1'b1);

    // tie: fetch of the stored word against a D load
    bus.if_addr = 32'h20;
    set_d(1'b0, 32'h10, 32'h0, MT_W);
`ifdef MEM_ARB_RR_EN
    push(PORT_IF, 32'h20, 1'b0, MT_W, 32'h0, 32'h12345678, 1'b0, 0);
    push(PORT_D, 32'h10, 1'b0, MT_W, 32'h0, 32'hDEADBEEF, 1'b0, 0);
`else
    push(PORT_D, 32'h10, 1'b0, MT_W, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    push(PORT_IF, 32'h20, 1'b0, MT_W, 32'h0, 32'h12345678, 1'b0, 0);
`endif
    serve(1'b1, 1'b1);

    // memory never raises busy: timeout after 16 WAIT_BUSY cycles
    mem_dead = 1'b1;
    set_d(1'b0, 32'h30, 32'h0, MT_W);
    push(PORT_D, 32'h30, 1'b0, MT_W, 32'h0, 32'hDEADBEEF, 1'b1, 17);
    serve(1'b0, 1'b1);
    mem_dead = 1'b0;

    // reset during WAIT_DONE of a fetch
    bus.if_addr = 32'h10;
    bus.if_req = 1'b1;
    for (int n = 0; n < 20 && !bus.mem_ld; n++) @(negedge clk);
    chk("abort_ld_seen", {31'b0, bus.mem_ld}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    bus.if_req = 1'b0;
    @(negedge clk);
    chk_reset_outs("mid_rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // fetch after reset completes normally
    push(PORT_IF, 32'h10, 1'b0, MT_W, 32'h0, 32'hDEADBEEF, 1'b0, 4);
    serve(1'b1, 1'b0);

    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester front end for the shared unified `memory` block (32-bit word, negedge-sequenced, mem_ld start pulse, busy handshake).
- Arbitrates between instruction fetch (IF) and data access (D).
- Latches the winner's command and holds it stable on the memory pins for the whole transaction.
- Sequences the mem_ld pulse and the busy handshake, then returns read data with a one-cycle ack.
- Sits between the microcode sequencer's fetch/load-store paths and `memory`.

Parameters:
- MAX_WAIT, 16: posedge cycles allowed in any wait state before timeout.
- CW, 5: timeout counter width; must satisfy 2^CW > MAX_WAIT.

Ports:
- clk  in  1  system clock; all arbiter state updates on posedge.
- reset_n  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch request; level, held until if_ack.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word; valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; level, held until d_ack.
- d_we  in  1  1=store, 0=load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_mt  in  3  memory type (MT_W/H/B/HU/BU encodings from the shared constants).
- d_rdata  out  32  load data; valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse for data.
- err  out  1  one-cycle pulse on timeout, coincident with the ack.
- mem_address  out  32  to memory address.
- mem_data_input  out  32  to memory data_input.
- mem_data_output  in  32  from memory data_output.
- mem_ld  out  1  start pulse to memory.
- mem_wr  out  1  store enable to memory.
- mem_mt  out  3  to memory mt.
- mem_busy  in  1  from memory busy.

Behaviour:
- Reset (reset_n=0 at posedge):
  - State = IDLE; timeout counter = 0; rr pointer = IF.
  - Outputs: if_ack, d_ack, err, mem_ld, mem_wr = 0; mem_address, mem_data_input, if_rdata, d_rdata = 0; mem_mt = MT_W.
  - Reset mid-transaction abandons the transaction with no ack. A store whose MEM_DONE negedge has already passed stays written.
- IDLE:
  - Neither request: remain in IDLE.
  - One request: grant it.
  - Both requests: fixed priority, D wins.
  - On grant, latch the command into the mem_* registers and go to ISSUE.
  - IF grant: mem_wr=0, mem_mt=MT_W, mem_data_input=0.
  - D grant: mem_wr=d_we, mem_mt=d_mt, mem_data_input=d_wdata.
- ISSUE: mem_ld=1 for exactly this one cycle; go to WAIT_BUSY.
- WAIT_BUSY:
  - mem_busy=1: go to WAIT_DONE.
  - Otherwise increment the timeout counter; at MAX_WAIT go to RESP with the timeout flag set.
- WAIT_DONE:
  - mem_busy=0: capture mem_data_output into the granted port's rdata and go to RESP.
  - Otherwise count; at MAX_WAIT go to RESP with the timeout flag set.
- RESP:
  - Granted ack=1 for one cycle; err=1 in the same cycle if timed out.
  - Clear mem_wr; go to IDLE.
  - The requester drops req at the same edge it sees ack. A request still high in IDLE is a new request.
- Hold rules:
  - mem_address, mem_wr, mem_mt and mem_data_input stay constant from ISSUE through RESP.
  - Memory commits stores on the MEM_DONE negedge, so mem_wr must be held until then.
- Latency:
  - Minimum request-to-ack is 1 (IDLE) + 1 (ISSUE) + 1 (WAIT_BUSY) + memory latency + 1 (RESP).
  - No back-to-back transactions: at least one IDLE cycle between them.
- Request changes: requests arriving mid-transaction wait. The non-granted request is never dropped.
- Store ack: d_rdata is undefined but must not be X; it holds its last value.
- Mutual exclusion: if_ack and d_ack are never high in the same cycle.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, grant the port not served last.
  - The rr pointer updates on every grant.
- Not defined: fixed D-over-IF priority; the rr pointer logic is absent.

Decomposition:
- Shared package/header (alongside constants.svh) holds:
  - arb_state_t enum: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
  - arb_port_t: PORT_IF, PORT_D.
  - The MT_* encodings, reused, not redefined.
- Sub-module arb_pick: combinational grant from {if_req, d_req, rr_ptr}, returning a port and a valid bit. It keeps the macro-dependent logic isolated.

Test Plan:
- IF only, addr 0x10, memory word 0xDEADBEEF:
  - mem_ld high exactly 1 cycle with mem_address=0x10, mem_wr=0, mem_mt=MT_W.
  - if_ack 1 cycle with if_rdata=0xDEADBEEF; d_ack stays 0.
- D store, d_addr 0x20, d_wdata 0x12345678, MT_W, then IF fetch of 0x20:
  - mem_wr held high from ISSUE until busy falls.
  - Fetch returns 0x12345678.
- if_req and d_req raised in the same cycle, both held:
  - Without macro: d_ack precedes if_ack, with at least one IDLE between transactions.
  - With MEM_ARB_RR_EN after a prior D grant: IF served first.
- mem_busy tied 0 by the bench model:
  - After MAX_WAIT=16 cycles in WAIT_BUSY, d_ack and err pulse together for 1 cycle; state returns to IDLE.
- reset_n dropped during WAIT_DONE of a fetch:
  - No if_ack; all outputs at reset values next posedge.
  - A fetch issued after reset completes normally.
- D load MT_B at 0x23:
  - mem_mt=MT_B and mem_address=0x23 held stable through the transaction.
  - d_rdata equals the memory model's byte-load result.
